wave_gen: RTL and testbench

WAVE_GEN -- requirements
Module: wave_gen

---
 rtl/wave_gen_pkg.sv | 20 ++
 rtl/wave_gen_shaper.sv | 58 +++++
 rtl/wave_gen.sv | 81 ++++++++
 tb/tb_wave_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
//------------------------------------------------------------------------------
// wave_gen_pkg : shape encodings and field widths shared by the wave generator
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wave_gen_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TRI  = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_SQR  = 2'd2,
    MODE_MUTE = 2'd3
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/wave_gen_shaper.sv
//------------------------------------------------------------------------------
// wave_gen_shaper : combinational phase -> signed sample (TRI/SAW/SQR/MUTE),
//                   followed by an arithmetic right-shift attenuator
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wave_gen_shaper
  import wave_gen_pkg::*;
#(
  parameter int W  = 10,
  parameter int PW = 6,
  parameter int AW = $clog2(W)
) (
  input  logic [PW-1:0]       phase,
  input  mode_e               mode,
  input  logic [AW-1:0]       att,
  output logic signed [W-1:0] sample
);

  localparam int             TSH    = W + 1 - PW;
  localparam logic [PW-2:0]  QTR    = {1'b1, {(PW-2){1'b0}}};
  localparam logic [W-2:0]   FS_MAG = '1;

  logic [1:0]          quad;
  logic [PW-3:0]       q;
  logic [PW-2:0]       tri_m;
  logic [W-2:0]        tri_mag;
  logic signed [W-1:0] tri_s;
  logic signed [W-1:0] saw_s;
  logic signed [W-1:0] sqr_s;
  logic signed [W-1:0] raw;

  always_comb begin
    quad  = phase[PW-1:PW-2];
    q     = phase[PW-3:0];
    tri_m = quad[0] ? (QTR - {1'b0, q}) : {1'b0, q};
    // m == Q is the only magnitude whose shift reaches 2^(W-1); clamp it to FS
    tri_mag = tri_m[PW-2] ? FS_MAG : {tri_m[PW-3:0], {TSH{1'b0}}};
    tri_s   = quad[1] ? -$signed({1'b0, tri_mag}) : $signed({1'b0, tri_mag});

    // flipping the phase MSB yields (phase - N/2) as a PW-bit two's complement
    saw_s = $signed(W'({~phase[PW-1], phase[PW-2:0]}) << (W - PW));
    sqr_s = phase[PW-1] ? -$signed({1'b0, FS_MAG}) : $signed({1'b0, FS_MAG});

    case (mode)
      MODE_TRI: raw = tri_s;
      MODE_SAW: raw = saw_s;
      MODE_SQR: raw = sqr_s;
      default:  raw = '0;
    endcase

    sample = raw >>> att;
  end

endmodule

`default_nettype wire

// File: rtl/wave_gen.sv
//------------------------------------------------------------------------------
// wave_gen : phase-accumulating waveform generator with period-aligned config
//            latch, registered attenuated sample and start-of-period sync
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int W  = 10,
  parameter int PW = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   restart,
  input  logic [MODE_W-1:0]      mode,
  input  logic [$clog2(W)-1:0]   att,
  output logic signed [W-1:0]    wave,
  output logic [PW-1:0]          phase,
  output logic                   sync
);

  localparam int            AW   = $clog2(W);
  localparam logic [PW-1:0] LAST = '1;

  generate
    if (W < PW || PW < 3) begin : g_param_check
      $error("wave_gen: requires W >= PW and PW >= 3");
    end
  endgenerate

  mode_e               act_mode;
  logic [AW-1:0]       act_att;
  logic signed [W-1:0] sample;
  logic                load;
  logic                sync_pend;

  // config is only taken at a period boundary, so a period never changes shape
  assign load = restart || (ce && (phase == LAST));

  wave_gen_shaper #(
    .W  (W),
    .PW (PW),
    .AW (AW)
  ) u_shaper (
    .phase  (phase),
    .mode   (act_mode),
    .att    (act_att),
    .sample (sample)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= '0;
      act_mode  <= MODE_TRI;
      act_att   <= '0;
      wave      <= '0;
      sync_pend <= 1'b0;
      sync      <= 1'b0;
    end else begin
      if (restart) begin
        phase <= '0;
      end else if (ce) begin
        phase <= phase + 1'b1;
      end
      if (load) begin
        act_mode <= mode_e'(mode);
        act_att  <= att;
      end
      wave      <= sample;
      // phase reaches 0 one clock before wave carries its sample
      sync_pend <= load;
      sync      <= sync_pend;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wave_gen.sv
//------------------------------------------------------------------------------
// tb_wave_gen : directed stimulus with a queued scoreboard drained by a monitor
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wave_gen;
  import wave_gen_pkg::*;

  localparam int W  = 10;
  localparam int PW = 6;
  localparam int AW = $clog2(W);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ce;
  logic                restart;
  logic [MODE_W-1:0]   mode;
  logic [AW-1:0]       att;
  logic signed [W-1:0] wave;
  logic [PW-1:0]       phase;
  logic                sync;

  wave_gen #(.W(W), .PW(PW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .restart (restart),
    .mode    (mode),
    .att     (att),
    .wave    (wave),
    .phase   (phase),
    .sync    (sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  at;
    int                  kind;   // 0: sample check, 1: sync-count window
    logic signed [W-1:0] w;
    logic                s;
    logic [PW-1:0]       p;
    int                  from;
    int                  n;
    string               name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   sync_hist [0:4095];
  int   ph      = 0;
  int   ph_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every cycle is an output presentation; pop entries due now
  always @(negedge clk) begin : monitor
    exp_t e;
    int   sum;
    if (cyc < 4096) sync_hist[cyc] = sync;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.at < cyc) begin
        errors++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.at);
      end else if (e.kind == 0) begin
        if (wave !== e.w || sync !== e.s || phase !== e.p) begin
          errors++;
          $display("FAIL %s: got wave=%0d sync=%0b phase=%0d, expected wave=%0d sync=%0b phase=%0d",
                   e.name, wave, sync, phase, e.w, e.s, e.p);
        end
      end else begin
        sum = 0;
        for (int c = e.from + 1; c <= e.at; c++) sum += int'(sync_hist[c]);
        if (sum != e.n) begin
          errors++;
          $display("FAIL %s: got %0d sync pulses, expected %0d", e.name, sum, e.n);
        end
      end
    end
  end

  task automatic tick();
    int nxt;
    if (!rst_n)       nxt = 0;
    else if (restart) nxt = 0;
    else if (ce)      nxt = (ph + 1) % 64;
    else              nxt = ph;
    @(posedge clk);
    #1;
    ph_prev = ph;
    ph      = nxt;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // advance until wave carries the sample of phase 'target'
  task automatic goto_ph(input int target);
    int n = 0;
    do begin
      tick();
      n++;
    end while (ph_prev != target && n < 200);
    if (ph_prev != target) begin
      errors++;
      $display("FAIL goto_ph: phase %0d not reached within 200 clocks", target);
    end
  endtask

  task automatic exp_smp(input string nm, input int w, input logic s);
    exp_t e;
    e.at = cyc; e.kind = 0; e.w = W'(w); e.s = s; e.p = PW'(ph);
    e.from = 0; e.n = 0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_cnt(input string nm, input int from, input int n);
    exp_t e;
    e.at = cyc; e.kind = 1; e.w = '0; e.s = 1'b0; e.p = '0;
    e.from = from; e.n = n; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    rst_n = 1'b0; ce = 1'b0; restart = 1'b0; mode = MODE_TRI; att = '0;
    tick();
    ce = 1'b1; restart = 1'b1;              // reset must override both
    tick();
    exp_smp("reset", 0, 1'b0);
    restart = 1'b0;

    // triangle, full scale
    rst_n = 1'b1;
    tick();            exp_smp("rel_ph0", 0, 1'b0);
    goto_ph(8);        exp_smp("tri_ph8", 256, 1'b0);
    goto_ph(16);       exp_smp("tri_ph16", 511, 1'b0);
    goto_ph(32);       exp_smp("tri_ph32", 0, 1'b0);
    goto_ph(48);       exp_smp("tri_ph48", -511, 1'b0);
    goto_ph(0);        exp_smp("tri_wrap", 0, 1'b1);
    t = cyc;
    ticks(64);         exp_cnt("sync_per_64", t, 1);

    // sawtooth then square
    mode = MODE_SAW;
    goto_ph(0);        exp_smp("saw_ph0", -512, 1'b1);
    mode = MODE_SQR;
    goto_ph(1);        exp_smp("saw_ph1", -496, 1'b0);
    goto_ph(63);       exp_smp("saw_ph63", 496, 1'b0);
    goto_ph(0);        exp_smp("sqr_ph0", 511, 1'b1);
    goto_ph(31);       exp_smp("sqr_ph31", 511, 1'b0);
    goto_ph(32);       exp_smp("sqr_ph32", -511, 1'b0);
    mode = MODE_TRI;
    goto_ph(63);       exp_smp("sqr_held_ph63", -511, 1'b0);
    goto_ph(0);        exp_smp("tri_back_ph0", 0, 1'b1);

    // mid-period change must wait for the wrap
    goto_ph(20);       exp_smp("tri_ph20", 384, 1'b0);
    mode = MODE_SQR;
    goto_ph(24);       exp_smp("tri_hold_ph24", 256, 1'b0);
    goto_ph(40);       exp_smp("tri_hold_ph40", -256, 1'b0);
    goto_ph(0);        exp_smp("sqr_at_sync", 511, 1'b1);

    // attenuation and mute
    mode = MODE_TRI; att = AW'(1);
    goto_ph(63);       exp_smp("sqr_ph63_att0", -511, 1'b0);
    goto_ph(0);        exp_smp("tri_att1_ph0", 0, 1'b1);
    goto_ph(8);        exp_smp("tri_att1_ph8", 128, 1'b0);
    goto_ph(16);       exp_smp("tri_att1_peak", 255, 1'b0);
    goto_ph(48);       exp_smp("tri_att1_trough", -256, 1'b0);
    mode = MODE_MUTE; att = '0;
    goto_ph(0);        exp_smp("mute_ph0", 0, 1'b1);
    goto_ph(16);       exp_smp("mute_ph16", 0, 1'b0);
    goto_ph(48);       exp_smp("mute_ph48", 0, 1'b0);

    // ce toggling: phase 49 -> 50,50,51,51,52,52,53,53
    mode = MODE_TRI;
    for (int i = 0; i < 8; i++) begin
      ce = (i % 2 == 0);
      tick();
      exp_smp("ce_toggle", 0, 1'b0);
    end
    ce = 1'b1;

    // restart at phase 40 with immediate config load
    goto_ph(39);
    restart = 1'b1; mode = MODE_SAW;
    tick();            exp_smp("restart_ph40", -256, 1'b0);
    restart = 1'b0;
    t = cyc;
    tick();            exp_smp("restart_ph0", -512, 1'b1);
    ticks(8);          exp_cnt("restart_single", t, 1);

    // restart coinciding with the wrap
    goto_ph(62);
    restart = 1'b1;
    tick();            exp_smp("wrap_restart", 496, 1'b0);
    restart = 1'b0;
    t = cyc;
    tick();            exp_smp("wrap_restart_ph0", -512, 1'b1);
    ticks(5);          exp_cnt("wrap_restart_single", t, 1);

    // ce low while parked on phase 0
    goto_ph(63);
    ce = 1'b0;
    t = cyc;
    tick();            exp_smp("hold_ph0", -512, 1'b1);
    ticks(4);          exp_smp("hold_later", -512, 1'b0);
    exp_cnt("hold_sync_once", t, 1);
    ce = 1'b1;

    // reset mid-period
    goto_ph(29);
    rst_n = 1'b0;
    tick();            exp_smp("reset_mid", 0, 1'b0);
    rst_n = 1'b1;
    t = cyc;
    tick();            exp_smp("post_reset_ph0", 0, 1'b0);
    goto_ph(8);        exp_smp("post_reset_tri", 256, 1'b0);
    goto_ph(0);        exp_smp("post_reset_wrap", -512, 1'b1);
    exp_cnt("post_reset_first_sync", t, 1);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
